// File: rtl/perip_sram_ctrl_if.sv
// Request/response channel between a load/store master and the SRAM controller.
// Each request is one bus word. Each completion is a single rsp_valid pulse.
interface perip_sram_ctrl_if #(
  parameter int REQ_AW = 21,
  parameter int BUS_DW = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [REQ_AW-1:0]     req_addr;
  logic [BUS_DW-1:0]     req_wdata;
  logic [BUS_DW/8-1:0]   req_wstrb;
  logic                  rsp_valid;
  logic [BUS_DW-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/perip_sram_ctrl.sv
// Clocked async-SRAM controller. It splits one bus word into RATIO SRAM beats.
// Each beat has programmable wait states, and every pin is driven from a flop.
module perip_sram_ctrl #(
  parameter int AW      = 22,
  parameter int DW      = 16,
  parameter int BUS_DW  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic                CLK,
  input  logic                RST_n,
  perip_sram_ctrl_if.slave    bus,
  output logic                SRAM_CSn_io,
  output logic                SRAM_OEn_io,
  output logic                SRAM_WRn_io,
  output logic [DW/8-1:0]     SRAM_BEn_io,
  output logic [AW-1:0]       SRAM_ADDR_io,
  output logic [DW-1:0]       SRAM_DATA_IN_io,
  input  logic [DW-1:0]       SRAM_DATA_OUT_io,
  output logic [DW-1:0]       SRAM_DATA_t
);

  localparam int RATIO    = BUS_DW / DW;
  localparam int BEAT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int REQ_AW   = AW - $clog2(RATIO);
  localparam int BPB      = DW / 8;
  localparam int STRB_W   = BUS_DW / 8;
  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int WT_W     = $clog2(MAX_WAIT + 1);

  localparam logic [WT_W-1:0]  RD_LOAD   = WT_W'(RD_WAIT - 1);
  localparam logic [WT_W-1:0]  WR_LOAD   = WT_W'(WR_WAIT - 1);
  localparam logic [RATIO-1:0] ALL_BEATS = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RECOVER,
    ST_RESP
  } state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic [WT_W-1:0]     wait_reg, wait_next;
  logic                wen_reg;
  logic [REQ_AW-1:0]   addr_reg;
  logic [BUS_DW-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;

  logic                req_ready_reg;
  logic                rsp_valid_reg;
  logic [BUS_DW-1:0]   rsp_rdata_reg;
  logic                cs_n_reg, cs_n_next;
  logic                oe_n_reg, oe_n_next;
  logic                wr_n_reg, wr_n_next;
  logic [BPB-1:0]      ben_reg, ben_next;
  logic [AW-1:0]       addr_pin_reg, addr_pin_next;
  logic [DW-1:0]       data_in_reg, data_in_next;
  logic [DW-1:0]       data_t_reg, data_t_next;

  logic                accept;
  logic                rd_sample;
  logic [BEAT_W:0]     fb;
  logic [RATIO-1:0]    req_beat_en;
  logic [RATIO-1:0]    reg_beat_en;
  logic                wen_src;
  logic [REQ_AW-1:0]   addr_src;
  logic [BUS_DW-1:0]   wdata_src;
  logic [STRB_W-1:0]   wstrb_src;
  logic [AW-1:0]       addr_word;

  // A beat takes part in a write only if at least one of its byte strobes is set.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_beat_en
      assign req_beat_en[gi] = |bus.req_wstrb[gi*BPB +: BPB];
      assign reg_beat_en[gi] = |wstrb_reg[gi*BPB +: BPB];
    end
  endgenerate

  // On the accept edge the pins must already reflect the new request.
  // So the pin logic looks at the bus inputs directly, not at the latched copies.
  assign wen_src   = accept ? bus.req_wen   : wen_reg;
  assign addr_src  = accept ? bus.req_addr  : addr_reg;
  assign wdata_src = accept ? bus.req_wdata : wdata_reg;
  assign wstrb_src = accept ? bus.req_wstrb : wstrb_reg;

  generate
    if (RATIO == 1) begin : g_addr_flat
      assign addr_word = addr_src;
    end else begin : g_addr_beat
      assign addr_word = {addr_src, beat_next};
    end
  endgenerate

  // Returns {found, index} for the lowest enabled beat at or above start.
  function automatic logic [BEAT_W:0] first_beat(input logic [RATIO-1:0] mask,
                                                 input int start);
    logic [BEAT_W:0] res;
    res = '0;
    for (int b = RATIO - 1; b >= 0; b--) begin
      if (b >= start && mask[b]) begin
        res = {1'b1, BEAT_W'(b)};
      end
    end
    return res;
  endfunction

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    wait_next  = wait_reg;
    accept     = 1'b0;
    rd_sample  = 1'b0;
    fb         = '0;
    case (state_reg)
      ST_IDLE: begin
        if (req_ready_reg && bus.req_valid) begin
          accept = 1'b1;
          fb     = first_beat(bus.req_wen ? req_beat_en : ALL_BEATS, 0);
          if (fb[BEAT_W]) begin
            state_next = ST_ACCESS;
            beat_next  = fb[BEAT_W-1:0];
            wait_next  = bus.req_wen ? WR_LOAD : RD_LOAD;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_reg != '0) begin
          wait_next = wait_reg - 1'b1;
        end else if (wen_reg) begin
          state_next = ST_RECOVER;
        end else begin
          rd_sample = 1'b1;
          fb        = first_beat(ALL_BEATS, int'(beat_reg) + 1);
          if (fb[BEAT_W]) begin
            beat_next = fb[BEAT_W-1:0];
            wait_next = RD_LOAD;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RECOVER: begin
        fb = first_beat(reg_beat_en, int'(beat_reg) + 1);
        if (fb[BEAT_W]) begin
          state_next = ST_ACCESS;
          beat_next  = fb[BEAT_W-1:0];
          wait_next  = WR_LOAD;
        end else begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pin values for the coming cycle. They are decoded from the state being entered.
  always_comb begin
    cs_n_next     = 1'b1;
    oe_n_next     = 1'b1;
    wr_n_next     = 1'b1;
    ben_next      = '1;
    data_t_next   = '1;
    addr_pin_next = addr_pin_reg;
    data_in_next  = data_in_reg;
    case (state_next)
      ST_ACCESS: begin
        cs_n_next     = 1'b0;
        addr_pin_next = addr_word;
        if (wen_src) begin
          wr_n_next    = 1'b0;
          ben_next     = ~wstrb_src[beat_next*BPB +: BPB];
          data_t_next  = '0;
          data_in_next = wdata_src[beat_next*DW +: DW];
        end else begin
          oe_n_next = 1'b0;
          ben_next  = '0;
        end
      end
      ST_RECOVER: begin
        cs_n_next   = 1'b0;
        ben_next    = ~wstrb_src[beat_next*BPB +: BPB];
        data_t_next = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      wait_reg      <= '0;
      wen_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      cs_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      wr_n_reg      <= 1'b1;
      ben_reg       <= '1;
      addr_pin_reg  <= '0;
      data_in_reg   <= '0;
      data_t_reg    <= '1;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      wait_reg      <= wait_next;
      req_ready_reg <= (state_next == ST_IDLE);
      rsp_valid_reg <= (state_next == ST_RESP);
      cs_n_reg      <= cs_n_next;
      oe_n_reg      <= oe_n_next;
      wr_n_reg      <= wr_n_next;
      ben_reg       <= ben_next;
      addr_pin_reg  <= addr_pin_next;
      data_in_reg   <= data_in_next;
      data_t_reg    <= data_t_next;
      if (accept) begin
        wen_reg       <= bus.req_wen;
        addr_reg      <= bus.req_addr;
        wdata_reg     <= bus.req_wdata;
        wstrb_reg     <= bus.req_wstrb;
        rsp_rdata_reg <= '0;
      end
      if (rd_sample) begin
        rsp_rdata_reg[beat_reg*DW +: DW] <= SRAM_DATA_OUT_io;
      end
    end
  end

  assign bus.req_ready     = req_ready_reg;
  assign bus.rsp_valid     = rsp_valid_reg;
  assign bus.rsp_rdata     = rsp_rdata_reg;
  assign SRAM_CSn_io       = cs_n_reg;
  assign SRAM_OEn_io       = oe_n_reg;
  assign SRAM_WRn_io       = wr_n_reg;
  assign SRAM_BEn_io       = ben_reg;
  assign SRAM_ADDR_io      = addr_pin_reg;
  assign SRAM_DATA_IN_io   = data_in_reg;
  assign SRAM_DATA_t       = data_t_reg;

endmodule
